sigmoid: RTL and testbench



---
 rtl/sigmoid_if.sv | 12 +
 rtl/sigmoid.sv | 72 +++++++
 tb/tb_sigmoid.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_if.sv
// sigmoid_if: enable/done handshake and operand/result vectors for the sigmoid block
interface sigmoid_if #(
  parameter int WIDTH = 128,
  parameter int DATA_WIDTH = 16
);
  logic enable;
  logic [DATA_WIDTH-1:0] input_vector [WIDTH];
  logic [DATA_WIDTH-1:0] output_vector [WIDTH];
  logic done;
  modport master (output enable, input_vector, input output_vector, done);
  modport slave (input enable, input_vector, output output_vector, done);
endinterface

// File: rtl/sigmoid.sv
// sigmoid: LANES-per-clock hard-sigmoid over a WIDTH-element fixed-point vector
// Define SIGMOID_PLAN_EN to replace the linear core with the PLAN piecewise curve.
module sigmoid #(
  parameter int WIDTH = 128,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int LANES = 8
) (
  input logic clk,
  input logic reset,
  sigmoid_if.slave io
);
  localparam int AW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2;
  localparam logic [AW-1:0] LAST = AW'(WIDTH - LANES);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0] HALF = DATA_WIDTH'(1 << (FRAC_BITS - 1));
  localparam logic signed [DATA_WIDTH-1:0] T = DATA_WIDTH'(4 << FRAC_BITS);
`ifdef SIGMOID_PLAN_EN
  localparam logic [DATA_WIDTH-1:0] P_HI = DATA_WIDTH'(5 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0] P_MID = DATA_WIDTH'(19 << (FRAC_BITS - 3));
  localparam logic [DATA_WIDTH-1:0] C_HI = DATA_WIDTH'((27 << FRAC_BITS) >> 5);
  localparam logic [DATA_WIDTH-1:0] C_MID = DATA_WIDTH'(5 << (FRAC_BITS - 3));
`endif

  function automatic logic [DATA_WIDTH-1:0] act(input logic signed [DATA_WIDTH-1:0] x);
`ifdef SIGMOID_PLAN_EN
    logic [DATA_WIDTH-1:0] a, y;
    a = x[DATA_WIDTH-1] ? -x : x;
    y = a >= P_HI ? ONE : a >= P_MID ? (a >> 5) + C_HI : a >= ONE ? (a >> 3) + C_MID : (a >> 2) + HALF;
    return x[DATA_WIDTH-1] ? ONE - y : y;
`else
    // kept as its own signed statement so the shift stays arithmetic
    logic signed [DATA_WIDTH-1:0] lin;
    lin = $signed(HALF) + (x >>> 3);
    return x <= -T ? '0 : x >= T ? ONE : lin;
`endif
  endfunction

  logic [1:0] state;
  logic [AW-1:0] idx;
  logic done_r;
  logic wr;
  logic [DATA_WIDTH-1:0] lane_out [LANES];
  logic [WIDTH-1:0][DATA_WIDTH-1:0] res;

  assign wr = state == COMPUTE && io.enable;
  assign io.done = done_r;

  always_comb
    for (int l = 0; l < LANES; l++) lane_out[l] = act(io.input_vector[idx + AW'(l)]);

  always_comb
    for (int i = 0; i < WIDTH; i++) io.output_vector[i] = res[i];

  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      done_r <= 1'b0;
      res <= '0;
    end else begin
      if (wr)
        for (int i = 0; i < WIDTH; i++)
          if (idx == AW'(i / LANES * LANES)) res[i] <= lane_out[i % LANES];
      state <= state == IDLE ? (io.enable ? COMPUTE : IDLE)
             : !io.enable ? IDLE
             : state == COMPUTE && idx == LAST ? DONE : state;
      idx <= wr ? idx + AW'(LANES) : '0;
      done_r <= io.enable && (state == DONE || (wr && idx == LAST));
    end
endmodule

// File: tb/tb_sigmoid.sv
// tb_sigmoid: randomized self-checking bench for sigmoid against an arithmetic model
module tb_sigmoid;
  localparam int W = 128, DW = 16, L = 8, RUN = W / L + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0;
  int in_v [W];
  int exp_o [W];

  sigmoid_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();
  sigmoid #(.WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(L)) dut (.clk(clk), .reset(reset), .io(bus));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int ref_sig(int x);
    if (x <= -1024) return 0;
    if (x >= 1024) return 256;
    return 128 + (x - (((x % 8) + 8) % 8)) / 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < W; i++) bus.input_vector[i] = 16'(in_v[i]);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < W; i++)
      in_v[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                             : int'($urandom_range(0, 2559)) - 1280;
    load();
  endtask

  task automatic commit(input int lo, input int hi);
    for (int i = lo; i < hi; i++) exp_o[i] = ref_sig(in_v[i]);
  endtask

  task automatic run(output int n);
    bus.enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 40);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    rand_inputs();
    tick();
    tick();
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    for (int i = 0; i < W; i++) begin
      exp_o[i] = 0;
      tests++;
      if (bus.output_vector[i] !== 16'h0) begin fails++; $display("FAIL reset_out[%0d] got %h want 0000", i, bus.output_vector[i]); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_thresholds();
    int thr_in [7] = '{-1152, -1024, -512, 0, 512, 1024, 1152};
    int thr_exp [7] = '{0, 0, 'h40, 'h80, 'hC0, 'h100, 'h100};
    int n;
    rand_inputs();
    for (int i = 0; i < 7; i++) in_v[i] = thr_in[i];
    load();
    run(n);
    commit(0, W);
    tests++;
    if (n !== RUN) begin fails++; $display("FAIL thr_latency got %0d want %0d", n, RUN); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(thr_exp[i])) begin fails++; $display("FAIL thr_const[%0d] got %h want %h", i, bus.output_vector[i], 16'(thr_exp[i])); end
    end
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL thr_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_large();
    int big_in [5] = '{-16384, -9216, 32767, 1, -1};
    int big_exp [5] = '{0, 0, 'h100, 'h80, 'h7F};
    int n;
    rand_inputs();
    for (int i = 0; i < 5; i++) in_v[i] = big_in[i];
    load();
    run(n);
    commit(0, W);
    tests++;
    if (n !== RUN) begin fails++; $display("FAIL large_latency got %0d want %0d", n, RUN); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(big_exp[i])) begin fails++; $display("FAIL large_const[%0d] got %h want %h", i, bus.output_vector[i], 16'(big_exp[i])); end
    end
    for (int i = 5; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL large_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    int n;
    for (int i = 0; i < W; i++) in_v[i] = -1280 + i * 2560 / (W - 1);
    load();
    run(n);
    commit(0, W);
    tests++;
    if (n !== RUN) begin fails++; $display("FAIL ramp_latency got %0d want %0d", n, RUN); end
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL ramp_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_timing();
    int k;
    rand_inputs();
    commit(0, W);
    bus.enable = 1'b1;
    for (int e = 1; e <= RUN; e++) begin
      tick();
      tests++;
      if (bus.done !== (e == RUN)) begin fails++; $display("FAIL timing_done edge %0d got %b want %b", e, bus.done, e == RUN); end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      k = int'($urandom_range(0, W - 1));
      tests += 2;
      if (bus.done !== 1'b1) begin fails++; $display("FAIL timing_hold cycle %0d got %b want 1", c, bus.done); end
      if (bus.output_vector[k] !== 16'(exp_o[k])) begin fails++; $display("FAIL timing_held[%0d] got %h want %h", k, bus.output_vector[k], 16'(exp_o[k])); end
    end
    bus.enable = 1'b0;
    tick();
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL timing_drop got %b want 0", bus.done); end
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL timing_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
  endtask

  task automatic test_abort();
    int n;
    rand_inputs();
    bus.enable = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      tests++;
      if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_run_done edge %0d got %b want 0", e, bus.done); end
    end
    bus.enable = 1'b0;
    commit(0, 3 * L);
    for (int e = 0; e < 4; e++) begin
      tick();
      tests++;
      if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_idle_done cycle %0d got %b want 0", e, bus.done); end
    end
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL abort_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    run(n);
    commit(0, W);
    tests++;
    if (n !== RUN) begin fails++; $display("FAIL abort_rerun_latency got %0d want %0d", n, RUN); end
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL abort_rerun_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    rand_inputs();
    run(n1);
    commit(0, W);
    bus.enable = 1'b0;
    tick();
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL b2b_gap_done got %b want 0", bus.done); end
    rand_inputs();
    run(n2);
    tests += 2;
    if (n1 !== RUN) begin fails++; $display("FAIL b2b_first_latency got %0d want %0d", n1, RUN); end
    if (n2 !== RUN) begin fails++; $display("FAIL b2b_second_latency got %0d want %0d", n2, RUN); end
    commit(0, W);
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL b2b_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    rand_inputs();
    bus.enable = 1'b1;
    for (int e = 0; e < 6; e++) tick();
    reset = 1'b1;
    bus.enable = 1'b0;
    tick();
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    for (int i = 0; i < W; i++) begin
      exp_o[i] = 0;
      tests++;
      if (bus.output_vector[i] !== 16'h0) begin fails++; $display("FAIL rstmid_out[%0d] got %h want 0000", i, bus.output_vector[i]); end
    end
    reset = 1'b0;
    rand_inputs();
    tick();
    run(n);
    commit(0, W);
    tests++;
    if (n !== RUN) begin fails++; $display("FAIL rstmid_latency got %0d want %0d", n, RUN); end
    for (int i = 0; i < W; i++) begin
      tests++;
      if (bus.output_vector[i] !== 16'(exp_o[i])) begin fails++; $display("FAIL rstmid_rerun_out[%0d] got %h want %h", i, bus.output_vector[i], 16'(exp_o[i])); end
    end
    bus.enable = 1'b0;
    tick();
  endtask

  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_thresholds();
    test_large();
    test_ramp();
    test_timing();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
